// File: rtl/vga_timing_ctrl.sv
// Raster sequencer for the VGA text pipeline: pixel/line counters plus registered
// sync, active-window, coordinate and strobe outputs, all aligned to the counters.
module vga_timing_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int CHAR_W   = 8,
    parameter int CHAR_H   = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PIX_EN,
    output logic [9:0] horiz_c,
    output logic [9:0] vert_c,
    output logic       HSYNC_N,
    output logic       VSYNC_N,
    output logic       VIDEO_ON,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [6:0] char_col,
    output logic [5:0] char_row,
    output logic       LINE_START,
    output logic       FRAME_START
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);

    localparam int CW_SH = $clog2(CHAR_W);
    localparam int CH_SH = $clog2(CHAR_H);

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       von_nxt;
    logic [9:0] px_nxt;
    logic [9:0] py_nxt;

    // All decodes look at the next-state counters so outputs land on the same edge.
    always_comb begin
        h_nxt = horiz_c;
        v_nxt = vert_c;
        if (PIX_EN) begin
            if (horiz_c == H_MAX) begin
                h_nxt = '0;
                v_nxt = (vert_c == V_MAX) ? '0 : vert_c + 10'd1;
            end else begin
                h_nxt = horiz_c + 10'd1;
            end
        end
        von_nxt = (h_nxt >= H_START) && (h_nxt < H_END) &&
                  (v_nxt >= V_START) && (v_nxt < V_END);
        px_nxt  = von_nxt ? (h_nxt - H_START) : '0;
        py_nxt  = von_nxt ? (v_nxt - V_START) : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            horiz_c     <= '0;
            vert_c      <= '0;
            HSYNC_N     <= 1'b0;
            VSYNC_N     <= 1'b0;
            VIDEO_ON    <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            char_col    <= '0;
            char_row    <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            horiz_c     <= h_nxt;
            vert_c      <= v_nxt;
            HSYNC_N     <= (h_nxt >= H_SYNC_E);
            VSYNC_N     <= (v_nxt >= V_SYNC_E);
            VIDEO_ON    <= von_nxt;
            pix_x       <= px_nxt;
            pix_y       <= py_nxt;
            char_col    <= 7'(px_nxt >> CW_SH);
            char_row    <= 6'(py_nxt >> CH_SH);
            // An enabled edge that lands on column 0 can only be a wrap.
            LINE_START  <= PIX_EN && (h_nxt == '0);
            FRAME_START <= PIX_EN && (h_nxt == '0) && (v_nxt == '0);
        end
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three instances (default, reduced, tiny raster) checked
// every cycle against an arithmetic model driven by the count of enabled edges.
module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs_n;
        logic       vs_n;
        logic       von;
        logic [9:0] px;
        logic [9:0] py;
        logic [6:0] cc;
        logic [5:0] cr;
        logic       ls;
        logic       fs;
    } obs_t;

    typedef struct {
        int hs, hb, ha, hf, vs, vb, va, vf, cw, ch;
    } prm_t;

    localparam prm_t PA = '{96, 48, 640, 16, 2, 33, 480, 10, 8, 16};
    localparam prm_t PB = '{96, 48, 320, 8, 2, 33, 240, 10, 4, 8};
    localparam prm_t PC = '{4, 3, 16, 2, 2, 2, 8, 1, 2, 2};

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    logic       rst_a, en_a, a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_h, a_v, a_px, a_py;
    logic [6:0] a_cc;
    logic [5:0] a_cr;
    logic       rst_b, en_b, b_hs, b_vs, b_von, b_ls, b_fs;
    logic [9:0] b_h, b_v, b_px, b_py;
    logic [6:0] b_cc;
    logic [5:0] b_cr;
    logic       rst_c, en_c, c_hs, c_vs, c_von, c_ls, c_fs;
    logic [9:0] c_h, c_v, c_px, c_py;
    logic [6:0] c_cc;
    logic [5:0] c_cr;

    obs_t a_obs, b_obs, c_obs;
    assign a_obs = {a_h, a_v, a_hs, a_vs, a_von, a_px, a_py, a_cc, a_cr, a_ls, a_fs};
    assign b_obs = {b_h, b_v, b_hs, b_vs, b_von, b_px, b_py, b_cc, b_cr, b_ls, b_fs};
    assign c_obs = {c_h, c_v, c_hs, c_vs, c_von, c_px, c_py, c_cc, c_cr, c_ls, c_fs};

    vga_timing_ctrl dut_a (
        .CLK(CLK), .RST_N(rst_a), .PIX_EN(en_a), .horiz_c(a_h), .vert_c(a_v),
        .HSYNC_N(a_hs), .VSYNC_N(a_vs), .VIDEO_ON(a_von), .pix_x(a_px), .pix_y(a_py),
        .char_col(a_cc), .char_row(a_cr), .LINE_START(a_ls), .FRAME_START(a_fs)
    );

    vga_timing_ctrl #(
        .H_ACTIVE(320), .H_FRONT(8), .V_ACTIVE(240), .CHAR_W(4), .CHAR_H(8)
    ) dut_b (
        .CLK(CLK), .RST_N(rst_b), .PIX_EN(en_b), .horiz_c(b_h), .vert_c(b_v),
        .HSYNC_N(b_hs), .VSYNC_N(b_vs), .VIDEO_ON(b_von), .pix_x(b_px), .pix_y(b_py),
        .char_col(b_cc), .char_row(b_cr), .LINE_START(b_ls), .FRAME_START(b_fs)
    );

    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(8), .V_FRONT(1), .CHAR_W(2), .CHAR_H(2)
    ) dut_c (
        .CLK(CLK), .RST_N(rst_c), .PIX_EN(en_c), .horiz_c(c_h), .vert_c(c_v),
        .HSYNC_N(c_hs), .VSYNC_N(c_vs), .VIDEO_ON(c_von), .pix_x(c_px), .pix_y(c_py),
        .char_col(c_cc), .char_row(c_cr), .LINE_START(c_ls), .FRAME_START(c_fs)
    );

    // Expected outputs after k enabled edges since reset; en is the enable of the last edge.
    function automatic obs_t model(prm_t p, int k, logic en);
        obs_t o;
        int ht, vt, h, v, hst, vst, px, py;
        ht  = p.hs + p.hb + p.ha + p.hf;
        vt  = p.vs + p.vb + p.va + p.vf;
        h   = k % ht;
        v   = (k / ht) % vt;
        hst = p.hs + p.hb;
        vst = p.vs + p.vb;
        o.h    = 10'(h);
        o.v    = 10'(v);
        o.hs_n = (h >= p.hs);
        o.vs_n = (v >= p.vs);
        o.von  = (h >= hst) && (h < hst + p.ha) && (v >= vst) && (v < vst + p.va);
        px     = o.von ? h - hst : 0;
        py     = o.von ? v - vst : 0;
        o.px   = 10'(px);
        o.py   = 10'(py);
        o.cc   = 7'(px / p.cw);
        o.cr   = 6'(py / p.ch);
        o.ls   = en && (k > 0) && (h == 0);
        o.fs   = o.ls && (v == 0);
        return o;
    endfunction

    task automatic test_reset();
        obs_t e;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
        repeat (3) @(negedge CLK);
        e = model(PA, 0, 1'b0);
        n_total++;
        if (a_obs !== e) $display("FAIL reset_a got=%h exp=%h", a_obs, e); else n_pass++;
        e = model(PB, 0, 1'b0);
        n_total++;
        if (b_obs !== e) $display("FAIL reset_b got=%h exp=%h", b_obs, e); else n_pass++;
        e = model(PC, 0, 1'b0);
        n_total++;
        if (c_obs !== e) $display("FAIL reset_c got=%h exp=%h", c_obs, e); else n_pass++;
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    endtask

    // Default raster, mostly-enabled random PIX_EN, through the top of the active area.
    task automatic test_default_window();
        obs_t e;
        int k = 0;
        int last_ls = -1;
        int target = 36 * 800 + 40;
        rst_a = 1'b1;
        for (int c = 0; c < 2 * target && k < target; c++) begin
            en_a = ($urandom_range(0, 7) != 0);
            @(posedge CLK);
            if (en_a) k++;
            @(negedge CLK);
            e = model(PA, k, en_a);
            n_total++;
            if (a_obs !== e) $display("FAIL default_run k=%0d got=%h exp=%h", k, a_obs, e);
            else n_pass++;
            if (e.v == 10'd35 && e.h == 10'd143) begin
                n_total++;
                if (a_von !== 1'b0) $display("FAIL video_143 got=%b exp=0", a_von); else n_pass++;
            end
            if (e.v == 10'd35 && e.h == 10'd144) begin
                n_total++;
                if ({a_von, a_px, a_py} !== {1'b1, 10'd0, 10'd0})
                    $display("FAIL video_144 got=%b/%0d/%0d exp=1/0/0", a_von, a_px, a_py);
                else n_pass++;
            end
            if (e.v == 10'd35 && e.h == 10'd783) begin
                n_total++;
                if ({a_px, a_cc} !== {10'd639, 7'd79})
                    $display("FAIL video_783 got=%0d/%0d exp=639/79", a_px, a_cc);
                else n_pass++;
            end
            if (e.v == 10'd35 && e.h == 10'd784) begin
                n_total++;
                if ({a_von, a_px} !== {1'b0, 10'd0})
                    $display("FAIL video_784 got=%b/%0d exp=0/0", a_von, a_px);
                else n_pass++;
            end
            if (a_ls) begin
                if (last_ls >= 0) begin
                    n_total++;
                    if (k - last_ls != 800) $display("FAIL line_period got=%0d exp=800", k - last_ls);
                    else n_pass++;
                end
                last_ls = k;
            end
        end
        n_total++;
        if (k < target) $display("FAIL default_budget got=%0d exp=%0d", k, target); else n_pass++;

        // Asynchronous reset landing between edges, mid-line.
        en_a = 1'b1;
        @(negedge CLK);
        k++;
        rst_a = 1'b0;
        #1;
        e = model(PA, 0, 1'b0);
        n_total++;
        if (a_obs !== e) $display("FAIL async_reset_a got=%h exp=%h", a_obs, e); else n_pass++;
        @(negedge CLK);
        rst_a = 1'b1;
        k = 0;
        for (int c = 0; c < 900; c++) begin
            @(posedge CLK);
            k++;
            @(negedge CLK);
            e = model(PA, k, 1'b1);
            n_total++;
            if (a_obs !== e) $display("FAIL default_resume k=%0d got=%h exp=%h", k, a_obs, e);
            else n_pass++;
        end
        en_a = 1'b0;
    endtask

    // Reduced raster: 472-pixel lines, character cells of 4x8.
    task automatic test_nondefault();
        obs_t e;
        int k = 0;
        int last_ls = -1;
        int target = 36 * 472 + 20;
        rst_b = 1'b1;
        for (int c = 0; c < 2 * target && k < target; c++) begin
            en_b = ($urandom_range(0, 7) != 0);
            @(posedge CLK);
            if (en_b) k++;
            @(negedge CLK);
            e = model(PB, k, en_b);
            n_total++;
            if (b_obs !== e) $display("FAIL nondefault_run k=%0d got=%h exp=%h", k, b_obs, e);
            else n_pass++;
            if (e.v == 10'd35 && e.h == 10'd463) begin
                n_total++;
                if ({b_px, b_cc} !== {10'd319, 7'd79})
                    $display("FAIL nondefault_edge got=%0d/%0d exp=319/79", b_px, b_cc);
                else n_pass++;
            end
            if (b_ls) begin
                if (last_ls >= 0) begin
                    n_total++;
                    if (k - last_ls != 472) $display("FAIL nondefault_period got=%0d exp=472", k - last_ls);
                    else n_pass++;
                end
                last_ls = k;
            end
        end
        n_total++;
        if (k < target) $display("FAIL nondefault_budget got=%0d exp=%0d", k, target); else n_pass++;
        en_b = 1'b0;
    endtask

    // Tiny raster (25x13) at 1-in-2 enable: full frames, double wraps, strobe widths.
    task automatic test_half_rate();
        obs_t e;
        int k = 0;
        int cyc = 0;
        int last_ls = -1;
        int last_fs = -1;
        int n_fs = 0;
        logic prev_fs = 1'b0;
        rst_c = 1'b1;
        for (int c = 0; c < 3 * 325 * 2 + 10; c++) begin
            en_c = (c % 2 == 0);
            @(posedge CLK);
            cyc++;
            if (en_c) k++;
            @(negedge CLK);
            e = model(PC, k, en_c);
            n_total++;
            if (c_obs !== e) $display("FAIL half_rate k=%0d got=%h exp=%h", k, c_obs, e);
            else n_pass++;
            if (e.fs) begin
                n_total++;
                if ({c_h, c_v, c_ls, c_fs, c_hs, c_vs} !== {10'd0, 10'd0, 4'b1100})
                    $display("FAIL double_wrap got=%0d/%0d/%b%b%b%b exp=0/0/1100",
                             c_h, c_v, c_ls, c_fs, c_hs, c_vs);
                else n_pass++;
            end
            if (prev_fs) begin
                n_total++;
                if ({c_ls, c_fs} !== 2'b00) $display("FAIL strobe_drop got=%b%b exp=00", c_ls, c_fs);
                else n_pass++;
            end
            prev_fs = c_fs;
            if (c_ls) begin
                if (last_ls >= 0) begin
                    n_total++;
                    if (cyc - last_ls != 50) $display("FAIL half_line_clks got=%0d exp=50", cyc - last_ls);
                    else n_pass++;
                end
                last_ls = cyc;
            end
            if (c_fs) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_total++;
                    if (cyc - last_fs != 650) $display("FAIL half_frame_clks got=%0d exp=650", cyc - last_fs);
                    else n_pass++;
                end
                last_fs = cyc;
            end
        end
        n_total++;
        if (n_fs != 3) $display("FAIL half_frame_count got=%0d exp=3", n_fs); else n_pass++;
        en_c = 1'b0;
    endtask

    // Random enable, reset mid-frame, then the first FRAME_START must come a full frame later.
    task automatic test_reset_mid_frame();
        obs_t e;
        int k = 0;
        int first_fs = -1;
        rst_c = 1'b0;
        @(negedge CLK);
        rst_c = 1'b1;
        for (int c = 0; c < 4000 && k < 190; c++) begin
            en_c = $urandom_range(0, 1);
            @(posedge CLK);
            if (en_c) k++;
            @(negedge CLK);
            e = model(PC, k, en_c);
            n_total++;
            if (c_obs !== e) $display("FAIL random_c k=%0d got=%h exp=%h", k, c_obs, e);
            else n_pass++;
        end
        en_c = 1'b1;
        @(posedge CLK);
        #2;
        rst_c = 1'b0;
        #1;
        e = model(PC, 0, 1'b0);
        n_total++;
        if (c_obs !== e) $display("FAIL async_reset_c got=%h exp=%h", c_obs, e); else n_pass++;
        @(negedge CLK);
        rst_c = 1'b1;
        k = 0;
        for (int c = 0; c < 4000 && k < 2 * 325 + 5; c++) begin
            en_c = $urandom_range(0, 1);
            @(posedge CLK);
            if (en_c) k++;
            @(negedge CLK);
            e = model(PC, k, en_c);
            n_total++;
            if (c_obs !== e) $display("FAIL resume_c k=%0d got=%h exp=%h", k, c_obs, e);
            else n_pass++;
            if (c_fs && first_fs < 0) first_fs = k;
        end
        n_total++;
        if (first_fs != 325) $display("FAIL first_frame_start got=%0d exp=325", first_fs);
        else n_pass++;
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        @(negedge CLK);
        test_default_window();
        test_nondefault();
        test_half_rate();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Master raster sequencer for the VGA text-mode pipeline. Owns the horizontal and vertical pixel counters and advances them on a pixel-clock enable. From those counters it generates the sync lines, the active-video window, pixel and character-cell coordinates, and line/frame strobes. Every sync checker, glyph fetch and colour stage downstream takes its counters and timing from this block.

## Interface
Parameters (defaults give 640x480@60, 25 MHz pixel rate):
- H_SYNC, 96, hsync width in pixels
- H_BACK, 48, horizontal back porch
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch
- CHAR_W, 8, character cell width (power of two)
- CHAR_H, 16, character cell height (power of two)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- PIX_EN  in  1  pixel-clock enable; counters advance only on CLK edges where PIX_EN=1
- horiz_c  out  10  horizontal counter, 0..H_TOTAL-1
- vert_c  out  10  vertical counter, 0..V_TOTAL-1
- HSYNC_N  out  1  horizontal sync to connector, low during sync
- VSYNC_N  out  1  vertical sync to connector, low during sync
- VIDEO_ON  out  1  high inside the active window
- pix_x  out  10  active-area column, 0..H_ACTIVE-1; holds 0 outside the active window
- pix_y  out  10  active-area row, 0..V_ACTIVE-1; holds 0 outside the active window
- char_col  out  7  pix_x / CHAR_W
- char_row  out  6  pix_y / CHAR_H
- LINE_START  out  1  one-CLK strobe marking the start of a line
- FRAME_START  out  1  one-CLK strobe marking the start of a frame

## Operation
- Derived constants: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525).
- Region order per axis, from counter 0:
  - sync: [0, SYNC)
  - back porch: [SYNC, SYNC+BACK)
  - active: [SYNC+BACK, SYNC+BACK+ACTIVE)
  - front porch: up to TOTAL-1
- Default windows: horizontal active 144..783, vertical active 35..514.
- Counter sequencing on a CLK edge with PIX_EN=1:
  - If horiz_c = H_TOTAL-1: horiz_c wraps to 0.
    - If vert_c = V_TOTAL-1: vert_c wraps to 0.
    - Otherwise vert_c increments.
  - Otherwise horiz_c increments and vert_c holds.
- With PIX_EN=0, counters and all outputs hold, except that the strobes drop to 0.
- Decode rules:
  - HSYNC_N = 0 iff horiz_c < H_SYNC.
  - VSYNC_N = 0 iff vert_c < V_SYNC.
  - VIDEO_ON = 1 iff both counters are inside their active ranges.
  - pix_x = horiz_c - (H_SYNC+H_BACK) and pix_y = vert_c - (V_SYNC+V_BACK) when VIDEO_ON; both 0 otherwise.
  - char_col and char_row are shifts of pix_x and pix_y; no dividers.
- Strobes:
  - LINE_START = 1 for exactly one CLK when horiz_c becomes 0.
  - FRAME_START = 1 for exactly one CLK when both counters become 0, coincident with a LINE_START.
- Subtractions use 10-bit unsigned arithmetic. They are evaluated only inside the active window, so no underflow reaches the outputs.
- Counters never leave range. No state exists beyond the two counters and the registered outputs.

## Timing
- Every output is a register. Decodes are computed from the next-state counter values, so on every edge all outputs are mutually consistent with the horiz_c/vert_c they accompany: zero skew and zero latency relative to the counters.
- Reset (RST_N=0, takes effect immediately):
  - horiz_c = 0, vert_c = 0
  - HSYNC_N = 0, VSYNC_N = 0 (reset state is counter 0,0, which lies in sync)
  - VIDEO_ON = 0
  - pix_x, pix_y, char_col, char_row = 0
  - LINE_START = 0, FRAME_START = 0
- First edge after release with PIX_EN=1: horiz_c = 1. There is no FRAME_START for the reset frame; the first FRAME_START follows the first full wrap.
- Reset asserted mid-frame aborts the frame. The same reset values hold; the strobes and VIDEO_ON drop immediately.
- PIX_EN toggled arbitrarily, e.g. 1-in-2: timing is counted in enabled edges only; line and frame periods are unchanged in enabled-edge units.
- Line period: H_TOTAL enabled edges. Frame period: H_TOTAL*V_TOTAL enabled edges (420000).

## Test plan
- Reset then PIX_EN=1 constant:
  - HSYNC_N low for exactly 96 enables per line.
  - LINE_START every 800 enables.
  - FRAME_START every 420000 enables.
  - VSYNC_N low for lines 0..1 (1600 enables).
- Active-window edges:
  - At horiz_c=143, vert_c=35: VIDEO_ON=0.
  - At horiz_c=144: VIDEO_ON=1, pix_x=0, pix_y=0.
  - At horiz_c=783, vert_c=514: pix_x=639, pix_y=479, char_col=79, char_row=29.
  - At horiz_c=784: VIDEO_ON=0, pix_x=0.
- Double wrap at horiz_c=799, vert_c=524:
  - Next enabled edge gives both counters 0, LINE_START=1, FRAME_START=1, HSYNC_N=0, VSYNC_N=0.
  - Both strobes drop on the following edge.
- PIX_EN=1 every other CLK:
  - Counters step every 2 CLKs.
  - Strobes are exactly 1 CLK wide.
  - Line period is 1600 CLKs.
- Async reset mid-frame at horiz_c=400, vert_c=200, asserted between edges:
  - All outputs reach reset values before the next CLK edge.
  - After release, counting resumes from 0,0 and the first FRAME_START comes 420000 enables later.
- Non-default parameters: H_ACTIVE=320, H_FRONT=8, V_ACTIVE=240, CHAR_W=4, CHAR_H=8.
  - H_TOTAL=472.
  - At pix_x=319: char_col=79.
  - Wraps occur at 471 and at V_TOTAL-1=284.
